pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Top-level instruction sequencer for the 9-bit CPU.
- Owns the program counter.
- Fetches each 9-bit instruction and presents it to the decoder.
- Stalls on load/store memory handshakes.
- Applies branch/jump targets and stops the machine when the decoder flags done.
- Sits between instruction memory, the decoder, the data-memory port and the register/ALU commit strobes.

Parameters:
PC_W, 10, program counter width; PC wraps modulo 2^PC_W
START_PC, 0, PC value loaded on every start
WDOG_CYCLES, 255, watchdog limit in cycles (used only with SEQ_WATCHDOG_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins execution from START_PC
fetch_req  out  1  instruction-memory read request; address = pc
pc  out  PC_W  current program counter
instr_valid  in  1  instruction memory has returned the word for pc
ir_load  out  1  one-cycle strobe; latch fetched word into the IR feeding the decoder
done_in  in  1  decoder done flag for the current IR
load_en  in  1  decoder load flag
stor_en  in  1  decoder store flag
branch_take  in  1  datapath reports the taken condition for the current branch/jump
branch_tgt  in  PC_W  resolved target address
mem_req  out  1  data-memory request; held until acknowledged
mem_ack  in  1  data-memory completion
exec_en  out  1  one-cycle commit strobe for register/ALU/memory writeback
busy  out  1  high in FETCH, EXEC and MEM
halted  out  1  high in HALT
err  out  1  watchdog timeout flag (tied 0 without SEQ_WATCHDOG_EN)
cycle_cnt  out  16  cycles spent busy since the last start; saturates at 16'hFFFF

Behaviour:
Reset (async, rst_n=0):
- State IDLE; pc=START_PC; cycle_cnt=0.
- All strobes low; busy=0, halted=0, err=0.

State machine: IDLE, FETCH, EXEC, MEM, HALT.

IDLE:
- start=1: pc<=START_PC, cycle_cnt<=0, go to FETCH.

FETCH:
- fetch_req=1.
- instr_valid=1: ir_load=1 in the same cycle, go to EXEC.
- instr_valid is ignored in every other state.

EXEC (exactly one cycle), evaluated in priority order:
1. done_in=1: go to HALT; no exec_en; pc unchanged.
2. load_en or stor_en: go to MEM; mem_req is asserted from the next cycle.
3. Otherwise: exec_en=1; pc<=branch_take ? branch_tgt : pc+1; go to FETCH.

MEM:
- mem_req=1.
- mem_ack=1: exec_en=1, pc<=pc+1, go to FETCH.
- mem_ack is ignored outside MEM.

HALT:
- halted=1.
- start=1: clear halted and err, pc<=START_PC, cycle_cnt<=0, go to FETCH.

Latency:
- Minimum 2 cycles per non-memory instruction: FETCH with instr_valid already high, then EXEC.
- Memory instructions take 3 + wait cycles.

Boundary conditions:
- start while busy: ignored.
- pc = 2^PC_W-1 with pc+1: wraps to 0.
- done_in together with load_en: done wins, no memory access.
- branch_take is sampled only in EXEC.
- cycle_cnt increments every cycle busy=1 and holds at 16'hFFFF.
- Reset asserted mid-MEM: mem_req drops immediately (async); no exec_en is issued.

Optional Feature:
SEQ_WATCHDOG_EN
- Defined:
  - An 8-bit wait counter clears on entry to FETCH or MEM and counts each cycle without instr_valid/mem_ack.
  - When it reaches WDOG_CYCLES: err<=1, go to HALT, drop the request, no exec_en.
- Undefined:
  - No counter; FETCH and MEM wait indefinitely.
  - err tied 0.

Decomposition:
- Shared package (instr_pack): seq_state enum {IDLE, FETCH, EXEC, MEM, HALT}; PC_W default constant; START_PC constant.
- Sub-module sat_counter: 16-bit saturating cycle counter with clear and enable inputs; reused by the watchdog, width-parameterised.
- FSM and pc register stay in pc_sequencer.

Test Plan:
- Reset, then start, with instr_valid always high and no flags: pc goes 0,1,2,3; exec_en every 2nd cycle; ir_load pulses aligned with FETCH.
- At pc=5, branch_take=1 with branch_tgt=10'h3F0 → next fetch at pc=3F0. Repeat with branch_take=0 → pc=6.
- load_en at pc=2, mem_ack after 4 cycles → mem_req high exactly 4 cycles, single exec_en on the ack cycle, pc=3, busy throughout.
- done_in and stor_en together at pc=7 → HALT, halted=1, mem_req never high, pc stays 7. start pulse → pc=0, halted=0.
- pc=10'h3FF non-branch → pc wraps to 0. Extra start pulses while busy → no effect.
- SEQ_WATCHDOG_EN with WDOG_CYCLES=8, mem_ack never asserted → err=1 and HALT after 8 MEM cycles, no exec_en. Without the macro → still in MEM at cycle 100. rst_n low mid-MEM → all outputs return to reset values immediately.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the 9-bit CPU instruction sequencer:
// sequencer state encoding and default program-counter constants.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } seq_state_e;

    localparam int PC_W_DEF     = 10;
    localparam int START_PC_DEF = 0;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear.
// Clear has priority over enable; the count holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_ONE = W'(1);
    localparam logic [W-1:0] CNT_MAX = '1;

    // Count enabled cycles, stop at the maximum value, restart on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer for the 9-bit CPU: owns the program counter,
// fetches instructions, stalls on data-memory handshakes, applies
// branch targets and halts when the decoder reports done.
// Optional build macro SEQ_WATCHDOG_EN adds a wait-cycle watchdog that
// aborts a stalled fetch or memory access into HALT with err set.
//
// Handshakes: fetch_req is held for the whole FETCH state and the word
// is taken in the cycle instr_valid is high (ir_load strobes then);
// mem_req is held for the whole MEM state and the access completes in
// the cycle mem_ack is high (exec_en strobes then). Acknowledges seen
// outside their own state are ignored.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int START_PC    = START_PC_DEF,
    parameter int WDOG_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            fetch_req,
    output logic [PC_W-1:0] pc,
    input  logic            instr_valid,
    output logic            ir_load,
    input  logic            done_in,
    input  logic            load_en,
    input  logic            stor_en,
    input  logic            branch_take,
    input  logic [PC_W-1:0] branch_tgt,
    output logic            mem_req,
    input  logic            mem_ack,
    output logic            exec_en,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [15:0]     cycle_cnt
);

    localparam logic [PC_W-1:0] PC_START = PC_W'(START_PC);
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

    seq_state_e state;
    logic       restart;
    logic       timeout;

    // Outputs that depend only on the state register.
    assign fetch_req = (state == FETCH);
    assign mem_req   = (state == MEM);
    assign busy      = (state == FETCH) || (state == EXEC) || (state == MEM);
    assign halted    = (state == HALT);

    // Strobes that complete a handshake in the same cycle.
    assign ir_load = (state == FETCH) && instr_valid;
    assign exec_en = ((state == EXEC) && !done_in && !load_en && !stor_en)
                   || ((state == MEM) && mem_ack);

    // A start pulse is honoured only when the machine is not running.
    assign restart = start && ((state == IDLE) || (state == HALT));

    sat_counter #(.W(16)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart),
        .en    (busy),
        .cnt   (cycle_cnt)
    );

`ifdef SEQ_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(WDOG_CYCLES - 1);

    logic       waiting;
    logic [7:0] wd_cnt;
    logic       err_q;

    // Consecutive wait cycles; any non-waiting cycle clears the count, which
    // also clears it on every entry to FETCH or MEM.
    assign waiting = ((state == FETCH) && !instr_valid)
                  || ((state == MEM) && !mem_ack);
    assign timeout = waiting && (wd_cnt == WD_LAST);
    assign err     = err_q;

    sat_counter #(.W(8)) u_wdog_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!waiting),
        .en    (waiting),
        .cnt   (wd_cnt)
    );

    // Sticky timeout flag, cleared when the machine is restarted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (restart) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // Sequencer state machine and program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= PC_START;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= PC_START;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (instr_valid) begin
                        state <= EXEC;
                    end else if (timeout) begin
                        state <= HALT;
                    end
                end
                EXEC: begin
                    if (done_in) begin
                        state <= HALT;
                    end else if (load_en || stor_en) begin
                        state <= MEM;
                    end else begin
                        pc    <= branch_take ? branch_tgt : (pc + PC_ONE);
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        pc    <= pc + PC_ONE;
                        state <= FETCH;
                    end else if (timeout) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    if (start) begin
                        pc    <= PC_START;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Drivers push the expected fetch
// address and commit address of every instruction into queues; a monitor
// pops and compares them whenever ir_load or exec_en fires.
module tb_pc_sequencer;

    localparam int PC_W = 10;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            fetch_req;
    logic [PC_W-1:0] pc;
    logic            instr_valid;
    logic            ir_load;
    logic            done_in;
    logic            load_en;
    logic            stor_en;
    logic            branch_take;
    logic [PC_W-1:0] branch_tgt;
    logic            mem_req;
    logic            mem_ack;
    logic            exec_en;
    logic            busy;
    logic            halted;
    logic            err;
    logic [15:0]     cycle_cnt;

    int n_vec = 0;
    int n_err = 0;
    int mem_req_cycles = 0;

    logic [PC_W-1:0] fetch_q[$];
    logic [PC_W-1:0] exec_q[$];

    pc_sequencer #(
        .PC_W        (PC_W),
        .START_PC    (0),
        .WDOG_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .instr_valid (instr_valid),
        .ir_load     (ir_load),
        .done_in     (done_in),
        .load_en     (load_en),
        .stor_en     (stor_en),
        .branch_take (branch_take),
        .branch_tgt  (branch_tgt),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .exec_en     (exec_en),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .cycle_cnt   (cycle_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare strobed addresses against the expected queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) mem_req_cycles++;
            if (ir_load) begin
                if (fetch_q.size() == 0) check("unexpected_ir_load", {22'd0, pc}, 32'hFFFF_FFFF);
                else check("fetch_pc", {22'd0, pc}, {22'd0, fetch_q.pop_front()});
            end
            if (exec_en) begin
                if (exec_q.size() == 0) check("unexpected_exec_en", {22'd0, pc}, 32'hFFFF_FFFF);
                else check("exec_pc", {22'd0, pc}, {22'd0, exec_q.pop_front()});
            end
        end
    end

    // Driver: run one instruction starting in FETCH. ack_wait=0 means the
    // memory never acknowledges and the task returns in the first MEM cycle.
    task automatic do_instr(input logic [PC_W-1:0] addr, input logic ld, input logic st,
                            input logic dn, input logic br, input logic [PC_W-1:0] tgt,
                            input int ack_wait, input logic pulse_start);
        int n;
        n = 0;
        while (!fetch_req && n < 20) begin
            step();
            n++;
        end
        if (!fetch_req) check("fetch_timeout", 32'd0, 32'd1);
        fetch_q.push_back(addr);
        if (!dn && (!(ld || st) || ack_wait > 0)) exec_q.push_back(addr);
        instr_valid = 1'b1;
        step();
        load_en = ld; stor_en = st; done_in = dn; branch_take = br; branch_tgt = tgt;
        start = pulse_start;
        step();
        load_en = 0; stor_en = 0; done_in = 0; branch_take = 0; branch_tgt = '0;
        start = 0;
        if ((ld || st) && !dn && ack_wait > 0) begin
            for (int i = 1; i <= ack_wait; i++) begin
                if (i == ack_wait) mem_ack = 1'b1;
                step();
                mem_ack = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 0; start = 0; instr_valid = 1; done_in = 0; load_en = 0; stor_en = 0;
        branch_take = 0; branch_tgt = '0; mem_ack = 0;
        repeat (3) step();

        // Reset state
        check("rst_pc", {22'd0, pc}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_exec_en", {31'd0, exec_en}, 32'd0);
        check("rst_ir_load", {31'd0, ir_load}, 32'd0);
        check("rst_cycle_cnt", {16'd0, cycle_cnt}, 32'd0);
        rst_n = 1;
        step();
        check("idle_mem_ack_ignored", {31'd0, busy}, 32'd0);

        // Start a program
        start = 1;
        step();
        start = 0;
        check("start_busy", {31'd0, busy}, 32'd1);

        do_instr(10'h000, 0, 0, 0, 0, 10'h000, 0, 0);
        do_instr(10'h001, 0, 0, 0, 0, 10'h000, 0, 1);   // start while busy
        mem_req_cycles = 0;
        do_instr(10'h002, 1, 0, 0, 0, 10'h000, 4, 0);   // load, ack in 4th MEM cycle
        check("load_mem_req_cycles", mem_req_cycles, 32'd4);
        mem_req_cycles = 0;
        do_instr(10'h003, 0, 0, 0, 0, 10'h000, 0, 0);
        do_instr(10'h004, 0, 0, 0, 0, 10'h000, 0, 0);
        do_instr(10'h005, 0, 0, 0, 1, 10'h3F0, 0, 0);   // taken branch
        do_instr(10'h3F0, 0, 0, 0, 0, 10'h123, 0, 0);   // not taken
        do_instr(10'h3F1, 0, 0, 0, 1, 10'h3FF, 0, 0);
        do_instr(10'h3FF, 0, 0, 0, 0, 10'h000, 0, 0);   // wraps to 0
        do_instr(10'h000, 0, 0, 0, 1, 10'h007, 0, 0);
        do_instr(10'h007, 0, 1, 1, 0, 10'h000, 0, 0);   // done wins over store
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_busy", {31'd0, busy}, 32'd0);
        check("halt_pc", {22'd0, pc}, 32'h7);
        check("halt_no_mem_req", mem_req_cycles, 32'd0);
        check("halt_cycle_cnt", {16'd0, cycle_cnt}, 32'd26);
        step();
        check("halt_pc_hold", {22'd0, pc}, 32'h7);

        // Restart from HALT
        start = 1;
        step();
        start = 0;
        check("restart_pc", {22'd0, pc}, 32'd0);
        check("restart_halted", {31'd0, halted}, 32'd0);
        check("restart_cycle_cnt", {16'd0, cycle_cnt}, 32'd0);

        // Memory access that is never acknowledged
        do_instr(10'h000, 1, 0, 0, 0, 10'h000, 0, 0);
`ifdef SEQ_WATCHDOG_EN
        repeat (7) step();
        check("wdog_mem_req_8th", {31'd0, mem_req}, 32'd1);
        check("wdog_err_before", {31'd0, err}, 32'd0);
        step();
        check("wdog_err", {31'd0, err}, 32'd1);
        check("wdog_halted", {31'd0, halted}, 32'd1);
        check("wdog_mem_req_drop", {31'd0, mem_req}, 32'd0);
        start = 1;
        step();
        start = 0;
        check("wdog_err_clear", {31'd0, err}, 32'd0);
        do_instr(10'h000, 1, 0, 0, 0, 10'h000, 0, 0);
        repeat (2) step();
`else
        repeat (99) step();
        check("stall_mem_req_100", {31'd0, mem_req}, 32'd1);
        check("stall_busy_100", {31'd0, busy}, 32'd1);
`endif

        // Asynchronous reset in the middle of MEM
        rst_n = 0;
        #1;
        check("amid_mem_req", {31'd0, mem_req}, 32'd0);
        check("amid_exec_en", {31'd0, exec_en}, 32'd0);
        check("amid_busy", {31'd0, busy}, 32'd0);
        check("amid_pc", {22'd0, pc}, 32'd0);
        check("amid_cycle_cnt", {16'd0, cycle_cnt}, 32'd0);
        check("amid_err", {31'd0, err}, 32'd0);
        step();
        rst_n = 1;
        step();

        check("fetch_q_empty", fetch_q.size(), 32'd0);
        check("exec_q_empty", exec_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
